// File: rtl/csadd_pkg.sv
// Shared types and constants for the multi-precision add/sub sequencer.
package csadd_pkg;

    localparam int unsigned SLICE_W      = 8;
    localparam int unsigned SLICE_LEVELS = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte-index counter width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/csadd_sequencer_if.sv
// Operand request and result handshakes of the add/sub sequencer.
interface csadd_sequencer_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = csadd_pkg::SLICE_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, busy
    );

endinterface

// File: rtl/CSadder.sv
// Conditional-sum add/sub slice: bits must equal 2**levels.
module CSadder #(
    parameter int unsigned bits   = 8,
    parameter int unsigned levels = 3
) (
    input  logic [bits-1:0] x,
    input  logic [bits-1:0] y,
    input  logic            mode,
    input  logic            cin,
    output logic [bits-1:0] sum,
    output logic            cout
);

    logic [bits-1:0] yy;
    logic [bits-1:0] s0, s1, c0, c1;
    logic [bits-1:0] n_s0, n_s1, n_c0, n_c1;

    // Per-bit conditional sums, then pairwise block merges doubling each level.
    always_comb begin
        yy = y ^ {bits{mode}};
        s0 = x ^ yy;
        s1 = ~(x ^ yy);
        c0 = x & yy;
        c1 = x | yy;
        n_s0 = s0;
        n_s1 = s1;
        n_c0 = c0;
        n_c1 = c1;
        for (int l = 1; l <= int'(levels); l++) begin
            n_s0 = s0;
            n_s1 = s1;
            n_c0 = c0;
            n_c1 = c1;
            // Upper half of each merged block picks its sum by the lower half's carry.
            for (int j = 0; j < int'(bits); j++) begin
                if ((j % (1 << l)) >= (1 << (l - 1))) begin
                    n_s0[j] = c0[2 * (j >> l)] ? s1[j] : s0[j];
                    n_s1[j] = c1[2 * (j >> l)] ? s1[j] : s0[j];
                end
            end
            // Merged block carry selects the upper half's carry pair.
            for (int k = 0; k < (int'(bits) >> l); k++) begin
                n_c0[k] = c0[2 * k] ? c1[2 * k + 1] : c0[2 * k + 1];
                n_c1[k] = c1[2 * k] ? c1[2 * k + 1] : c0[2 * k + 1];
            end
            s0 = n_s0;
            s1 = n_s1;
            c0 = n_c0;
            c1 = n_c1;
        end
        sum  = cin ? s1 : s0;
        cout = cin ? c1[0] : c0[0];
    end

endmodule

// File: rtl/csadd_sequencer.sv
// Multi-precision add/subtract, one byte per clock through a shared 8-bit slice.
module csadd_sequencer
    import csadd_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    csadd_sequencer_if.slave  bus
);

    localparam int unsigned W     = SLICE_W * WORDS;
    localparam int unsigned IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;

    logic [SLICE_W-1:0] slice_x;
    logic [SLICE_W-1:0] slice_y;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign slice_x = a_q[SLICE_W * idx_q +: SLICE_W];
    assign slice_y = b_q[SLICE_W * idx_q +: SLICE_W];

    CSadder #(
        .bits   (SLICE_W),
        .levels (SLICE_LEVELS)
    ) u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .mode (op_q),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state: latch on accept, ripple bytes through the slice, hold until consumed.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    idx_d   = '0;
                    // Subtract is A + ~B + 1; the +1 enters as the first carry-in.
                    carry_d = (bus.op == OP_SUB);
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[SLICE_W * idx_q +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == IDX_LAST) begin
                    carry_out_d = slice_cout;
                    // Same-sign operands (B as seen after inversion) with a differing result sign.
                    overflow_d  = (a_q[W-1] == (b_q[W-1] ^ op_q)) &&
                                  (slice_sum[SLICE_W-1] != a_q[W-1]);
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_csadd_sequencer.sv
// Scoreboard bench for csadd_sequencer with an arithmetic reference model.
module tb_csadd_sequencer;
    import csadd_pkg::*;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 8 * WORDS;

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csadd_sequencer_if #(.WORDS(WORDS)) bus ();

    csadd_sequencer #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t bp_e;
    int   checks   = 0;
    int   failures = 0;
    bit   rand_bp  = 1'b0;

    // Reference: plain wide arithmetic and signed range test.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        exp_t   e;
        logic [W:0] s;
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_SUB) begin
            e.result = a - b;
            e.cout   = (a >= b);
            r        = sa - sb;
        end else begin
            s        = {1'b0, a} + {1'b0, b};
            e.result = s[W-1:0];
            e.cout   = s[W];
            r        = sa + sb;
        end
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare each presented result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", 64'(bus.result), 64'(mon_e.result));
                chk("carry_out", 64'(bus.carry_out), 64'(mon_e.cout));
                chk("overflow", 64'(bus.overflow), 64'(mon_e.ovf));
            end
        end
    end

    // Random backpressure, changed just after the rising edge.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Issue one operation; returns at the falling edge after the accept.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        @(posedge clk);
        sb_q.push_back(model(a, b, op));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.op       = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !bus.in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(sb_q.size() == 0 && bus.in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_ADD;
        bus.out_ready = 1'b1;

        // Reset values.
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_carry_out", 64'(bus.carry_out), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Latency: out_valid rises exactly WORDS cycles after the accept.
        issue(32'h0000_00FF, 32'h0000_0001, OP_ADD);
        for (int c = 0; c <= int'(WORDS); c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("latency_%0d", c), 64'(bus.out_valid), 64'(c == int'(WORDS)));
        end
        drain();

        // Directed corner cases.
        issue(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
        issue(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
        issue(32'h0000_0005, 32'h0000_0007, OP_SUB);
        issue(32'h8000_0000, 32'h0000_0001, OP_SUB);
        drain();

        // Backpressure: result held, in_ready low, new operands ignored.
        bus.out_ready = 1'b0;
        bp_e = model(32'hDEAD_BEEF, 32'h0102_0304, OP_ADD);
        issue(32'hDEAD_BEEF, 32'h0102_0304, OP_ADD);
        for (int n = 0; n < 50 && !bus.out_valid; n++) @(negedge clk);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus.in_valid = 1'b1;
                bus.a        = 32'h1111_1111;
                bus.b        = 32'h2222_2222;
                bus.op       = OP_SUB;
            end
            if (i == 6) bus.in_valid = 1'b0;
            chk("bp_hold_result", 64'(bus.result), 64'(bp_e.result));
            chk("bp_hold_flags", 64'({bus.carry_out, bus.overflow}), 64'({bp_e.cout, bp_e.ovf}));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus.out_valid || bus.busy) seen = 1'b1;
            end
            chk("bp_ignored_operands", 64'(seen), 64'd0);
        end

        // Reset mid-RUN while the third byte is in flight.
        issue(32'hAAAA_AAAA, 32'h5555_5555, OP_ADD);
        @(negedge clk);
        @(negedge clk);
        chk("midrun_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk("midrun_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrun_busy_rst", 64'(bus.busy), 64'd0);
        chk("midrun_result", 64'(bus.result), 64'd0);
        chk("midrun_flags", 64'({bus.carry_out, bus.overflow}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrun_in_ready", 64'(bus.in_ready), 64'd1);
        issue(32'h1234_5678, 32'h1111_1111, OP_ADD);
        drain();

        // Randomized traffic with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        @(posedge clk);
        rand_bp = 1'b0;
        #2 bus.out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csadd_sequencer.md
# csadd_sequencer

Multi-precision add/subtract sequencer built around the team's 8-bit conditional-sum add/sub slice. It accepts WORDS×8-bit operands through a valid/ready handshake and processes one byte per clock through a single shared slice, least-significant byte first. The carry is registered between bytes. It returns the full-width result with carry and signed-overflow flags through a second valid/ready handshake. It sits between the lab datapath's operand registers and its result consumer, replacing a wide combinational adder with one reused 8-bit slice.

## Interface
- WORDS, default 4: number of 8-bit slices; the operand width is W = 8·WORDS. Legal range is WORDS ≥ 1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- op  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum or difference, two's complement.
- carry_out  output  1  carry out of the MSB. For subtraction, 1 means no borrow (A ≥ B unsigned).
- overflow  output  1  signed overflow of the W-bit operation.
- busy  output  1  high in RUN or DONE.

## Operation
- States and transitions:
  - IDLE: in_ready=1. The accept is the cycle with in_valid&in_ready. On accept, latch a, b and op, set idx=0, set carry=op (the +1 for two's-complement subtract), and go to RUN.
  - RUN: drive the slice with x=a_reg[8·idx+:8], y=b_reg[8·idx+:8], mode=op_reg, cin=carry.
    - Each clock, write the slice sum into result_reg[8·idx+:8], update carry ← slice cout, and increment idx.
    - When idx==WORDS−1, go to DONE instead of incrementing.
  - DONE: out_valid=1 and result, carry_out and overflow are held stable. The output handshake is the cycle with out_valid&out_ready; on it, go to IDLE.
- Overflow: let bt = b_reg[W−1]^op_reg. Then overflow = (a_reg[W−1]==bt) && (result_reg[W−1]!=a_reg[W−1]). It is registered when entering DONE.
- Input handling outside IDLE:
  - in_ready=0, so in_valid and the operand inputs are ignored.
  - Operands are not required to be held after the accept.
- WORDS=1 boundary: RUN lasts exactly one cycle.
- Reset values (asynchronous): state=IDLE, idx=0, carry=0, result=0, carry_out=0, overflow=0, out_valid=0, busy=0, in_ready=1 once rst_n is high.
- Reset mid-operation (RUN or DONE): the operation is discarded without any output handshake, and all outputs immediately take their reset values.

## Timing
- Latency: the accept occurs at edge T. RUN covers edges T+1 … T+WORDS, and out_valid rises after edge T+WORDS, i.e. WORDS cycles after the accept.
- Output handshake at edge U: out_valid falls after U and in_ready rises after U. The next accept is possible at U+1 at the earliest.
- Minimum issue interval: WORDS+2 cycles with out_ready held high.
- The slice is purely combinational. The critical path is the slice plus the carry register; no path combines both handshakes.
- in_ready and out_valid are decoded directly from state registers; neither depends combinationally on in_valid or out_ready.

## Structure
- Shared package `csadd_pkg`:
  - state enum {IDLE, RUN, DONE};
  - constant SLICE_W=8;
  - op encoding constants OP_ADD=0, OP_SUB=1.
- One sub-module instance: the existing 8-bit conditional-sum slice `CSadder` (bits=8, levels=3), used unchanged.
- idx counter width is $clog2(WORDS), minimum 1.

## Test plan
Bench setting: WORDS=4 unless stated otherwise.
- Add, single carry into byte 1: 0x000000FF + 0x00000001 → result 0x00000100, carry_out 0, overflow 0. out_valid rises exactly 4 cycles after the accept.
- Add, carry through every byte: 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry_out 1, overflow 0.
- Add, signed overflow: 0x7FFFFFFF + 0x00000001 → result 0x80000000, carry_out 0, overflow 1.
- Subtract:
  - 5 − 7 → result 0xFFFFFFFE, carry_out 0, overflow 0.
  - 0x80000000 − 1 → result 0x7FFFFFFF, carry_out 1, overflow 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE and pulse in_valid with new operands.
  - Required: result and flags stable, in_ready=0, and the new operands are not taken.
  - After out_ready=1: IDLE on the next edge.
- Reset mid-RUN: drop rst_n while idx=2.
  - Required: out_valid, busy, result and flags go to 0 immediately.
  - After release: in_ready=1, and a fresh 0x12345678 + 0x11111111 gives 0x23456789.
